// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the two-port memory arbiter.
// Holds the FSM state enum, default bus widths and port indices.
package mem_arb_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-port and memory-side signals of the arbiter.
// master = arbiter view, slave = caches plus main memory view.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
) ();

    logic              p0_request;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_din;
    logic              p0_ready;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_request;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_din;
    logic              p1_ready;
    logic [DATA_W-1:0] p1_rdata;

    logic [1:0]        grant;

    logic              u_request;
    logic              u_we;
    logic [ADDR_W-1:0] u_addr;
    logic [DATA_W-1:0] u_din;
    logic              u_ready;
    logic [DATA_W-1:0] u_dout;

    modport master (
        input  p0_request, p0_we, p0_addr, p0_din,
        input  p1_request, p1_we, p1_addr, p1_din,
        input  u_ready, u_dout,
        output p0_ready, p0_rdata,
        output p1_ready, p1_rdata,
        output grant,
        output u_request, u_we, u_addr, u_din
    );

    modport slave (
        output p0_request, p0_we, p0_addr, p0_din,
        output p1_request, p1_we, p1_addr, p1_din,
        output u_ready, u_dout,
        input  p0_ready, p0_rdata,
        input  p1_ready, p1_rdata,
        input  grant,
        input  u_request, u_we, u_addr, u_din
    );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select between the two cache ports.
// MEM_ARB_RR_EN selects round-robin ties; otherwise port 0 always wins.
module mem_arb_pick (
`ifdef MEM_ARB_RR_EN
    input  logic       last,
`endif
    input  logic       req0,
    input  logic       req1,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        unique case (1'b1)
            (req0 && !req1): win = 2'b01;
            (!req0 && req1): win = 2'b10;
            (req0 && req1): begin
`ifdef MEM_ARB_RR_EN
                // tie goes to whichever port did not win last time
                win = last ? 2'b01 : 2'b10;
`else
                win = 2'b01;
`endif
            end
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises I-cache (port 0) and D-cache (port 1) onto memory.
// Define MEM_ARB_RR_EN for round-robin ties instead of fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.master bus
);

    import mem_arb_pkg::*;

    state_t            state;
    state_t            nxt;
    logic [1:0]        win;
    logic [1:0]        grant_q;
    logic              load;
    logic              cap;
    logic              fin;
    logic              u_req_q;
    logic              u_we_q;
    logic [ADDR_W-1:0] u_addr_q;
    logic [DATA_W-1:0] u_din_q;
    logic              rdy0_q;
    logic              rdy1_q;
    logic [DATA_W-1:0] rd0_q;
    logic [DATA_W-1:0] rd1_q;

`ifdef MEM_ARB_RR_EN
    logic last;

    mem_arb_pick u_pick (
        .last (last),
        .req0 (bus.p0_request),
        .req1 (bus.p1_request),
        .win  (win)
    );
`else
    mem_arb_pick u_pick (
        .req0 (bus.p0_request),
        .req1 (bus.p1_request),
        .win  (win)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt  = state;
        load = 1'b0;
        cap  = 1'b0;
        fin  = 1'b0;
        unique case (state)
            IDLE: begin
                if (|win) begin
                    nxt  = ISSUE;
                    load = 1'b1;
                end
            end
            ISSUE: nxt = WAIT;
            WAIT: begin
                if (bus.u_ready) begin
                    nxt = DONE;
                    cap = 1'b1;
                end
            end
            DONE: begin
                nxt = IDLE;
                fin = 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q  <= '0;
            u_req_q  <= 1'b0;
            u_we_q   <= 1'b0;
            u_addr_q <= '0;
            u_din_q  <= '0;
            rdy0_q   <= 1'b0;
            rdy1_q   <= 1'b0;
            rd0_q    <= '0;
            rd1_q    <= '0;
`ifdef MEM_ARB_RR_EN
            last     <= 1'b1;
`endif
        end else begin
            u_req_q <= 1'b0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            if (load) begin
                grant_q <= win;
                u_req_q <= 1'b1;
`ifdef MEM_ARB_RR_EN
                last    <= win[PORT_D];
`endif
                unique case (1'b1)
                    win[PORT_I]: begin
                        u_we_q   <= bus.p0_we;
                        u_addr_q <= bus.p0_addr;
                        u_din_q  <= bus.p0_din;
                    end
                    win[PORT_D]: begin
                        u_we_q   <= bus.p1_we;
                        u_addr_q <= bus.p1_addr;
                        u_din_q  <= bus.p1_din;
                    end
                    default: ;
                endcase
            end
            if (cap) begin
                rdy0_q <= grant_q[PORT_I];
                rdy1_q <= grant_q[PORT_D];
                if (grant_q[PORT_I]) rd0_q <= bus.u_dout;
                if (grant_q[PORT_D]) rd1_q <= bus.u_dout;
            end
            if (fin) grant_q <= '0;
        end
    end

    assign bus.grant     = grant_q;
    assign bus.u_request = u_req_q;
    assign bus.u_we      = u_we_q;
    assign bus.u_addr    = u_addr_q;
    assign bus.u_din     = u_din_q;
    assign bus.p0_ready  = rdy0_q;
    assign bus.p1_ready  = rdy1_q;
    assign bus.p0_rdata  = rd0_q;
    assign bus.p1_rdata  = rd1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus scoreboard bench for mem_arbiter.
// Models main_memory with a one-cycle registered ready.
module tb_mem_arbiter;

    typedef struct {
        logic        r0;
        logic        we0;
        logic [5:0]  a0;
        logic [31:0] d0;
        logic        r1;
        logic        we1;
        logic [5:0]  a1;
        logic [31:0] d1;
        logic [31:0] x0;
        int          c0;
        logic [31:0] x1;
        int          c1;
    } vec_t;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } sb_t;

    logic clk;
    logic rst_n;
    logic force_rdy;
    logic mem_rdy;
    logic [31:0] mem_dout;
    logic [31:0] mem [64];

    int checks;
    int errors;
    sb_t sb[$];
    vec_t vecs[6];

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.u_ready = mem_rdy | force_rdy;
    assign bus.u_dout  = mem_dout;

    // main memory: write commits at the request edge, ready one cycle later
    always @(posedge clk) begin
        mem_rdy <= bus.u_request;
        if (bus.u_request) begin
            if (bus.u_we) begin
                mem[bus.u_addr] <= bus.u_din;
                mem_dout <= bus.u_din;
            end else begin
                mem_dout <= mem[bus.u_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input int port, input int k);
        sb_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ready: port %0d cycle %0d", port, k);
        end else begin
            e = sb.pop_front();
            chk("ready_port", port, e.port);
            chk("rdata", port == 1 ? bus.p1_rdata : bus.p0_rdata, e.data);
            chk("latency", k, e.cyc);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.p0_request = v.r0;
        bus.p0_we      = v.we0;
        bus.p0_addr    = v.a0;
        bus.p0_din     = v.d0;
        bus.p1_request = v.r1;
        bus.p1_we      = v.we1;
        bus.p1_addr    = v.a1;
        bus.p1_din     = v.d1;
    endtask

    // called at a negedge; that cycle is cycle 0
    task automatic run_vec(input vec_t v);
        int seen_u;
        int n;
        logic [1:0] g;
        seen_u = 0;
        n = int'(v.r0) + int'(v.r1);
        if (v.r0 && v.r1 && v.c1 < v.c0) begin
            sb.push_back('{1, v.x1, v.c1});
            sb.push_back('{0, v.x0, v.c0});
        end else begin
            if (v.r0) sb.push_back('{0, v.x0, v.c0});
            if (v.r1) sb.push_back('{1, v.x1, v.c1});
        end
        g = (sb[0].port == 1) ? 2'b10 : 2'b01;
        drive(v);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("grant_c1", {30'd0, bus.grant}, {30'd0, g});
                chk("u_req_c1", {31'd0, bus.u_request}, 32'd1);
            end
            if (bus.u_request) seen_u++;
            if (bus.p0_ready) begin
                pop_chk(0, k);
                bus.p0_request = 1'b0;
            end
            if (bus.p1_ready) begin
                pop_chk(1, k);
                bus.p1_request = 1'b0;
            end
        end
        chk("u_req_count", seen_u, n);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d completions missing", sb.size());
            sb.delete();
        end
        bus.p0_request = 1'b0;
        bus.p1_request = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {31'd0, |{bus.grant, bus.u_request, bus.u_we,
                          bus.u_addr, bus.u_din, bus.p0_ready,
                          bus.p1_ready, bus.p0_rdata, bus.p1_rdata}},
            32'd0);
    endtask

    initial begin
        int n0;
        int n1;
        vec_t v;
        checks = 0;
        errors = 0;
        force_rdy = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        end
        v = '{1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0,
              32'd0, 0, 32'd0, 0};
        drive(v);

        vecs[0] = '{1'b1, 1'b0, 6'd5, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0,
                    32'h17161514, 3, 32'd0, 0};
        vecs[1] = '{1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b1, 6'd2, 32'hDEADBEEF,
                    32'd0, 0, 32'hDEADBEEF, 3};
        vecs[2] = '{1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd2, 32'd0,
                    32'd0, 0, 32'hDEADBEEF, 3};
        vecs[3] = '{1'b1, 1'b0, 6'd1, 32'd0, 1'b1, 1'b0, 6'd3, 32'd0,
                    32'h07060504, 3, 32'h0F0E0D0C, 7};
        vecs[4] = '{1'b1, 1'b0, 6'd6, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0,
                    32'h1B1A1918, 3, 32'd0, 0};
`ifdef MEM_ARB_RR_EN
        vecs[5] = '{1'b1, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd4, 32'd0,
                    32'h03020100, 7, 32'h13121110, 3};
`else
        vecs[5] = '{1'b1, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd4, 32'd0,
                    32'h03020100, 3, 32'h13121110, 7};
`endif

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);

        force_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("idle_rdy_grant", {30'd0, bus.grant}, 32'd0);
            chk("idle_rdy_ready", {30'd0, bus.p1_ready, bus.p0_ready}, 32'd0);
        end
        force_rdy = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        chk("hold_p0_rdata", bus.p0_rdata, vecs[5].x0);
        chk("hold_p1_rdata", bus.p1_rdata, vecs[5].x1);

        v = '{1'b1, 1'b0, 6'd7, 32'd0, 1'b0, 1'b0, 6'd0, 32'd0,
              32'd0, 0, 32'd0, 0};
        drive(v);
        @(negedge clk);
        @(negedge clk);
        chk("wait_grant", {30'd0, bus.grant}, 32'd1);
        rst_n = 1'b0;
        bus.p0_request = 1'b0;
        @(negedge clk);
        chk_zero("mid_reset_outputs");
        rst_n = 1'b1;
        n0 = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.p0_ready) n0++;
        end
        chk("aborted_no_ready", n0, 0);
        v = '{1'b0, 1'b0, 6'd0, 32'd0, 1'b1, 1'b0, 6'd8, 32'd0,
              32'd0, 0, 32'h23222120, 3};
        run_vec(v);

        v = '{1'b1, 1'b0, 6'd9, 32'd0, 1'b1, 1'b0, 6'd10, 32'd0,
              32'd0, 0, 32'd0, 0};
        drive(v);
        n0 = 0;
        n1 = 0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (bus.p0_ready) n0++;
            if (bus.p1_ready) n1++;
        end
        bus.p0_request = 1'b0;
        bus.p1_request = 1'b0;
`ifdef MEM_ARB_RR_EN
        chk("contend_p0_count", n0, 3);
        chk("contend_p1_count", n1, 2);
`else
        chk("contend_p0_count", n0, 5);
        chk("starve_p1_count", n1, 0);
`endif
        repeat (3) @(negedge clk);
        chk("final_idle_grant", {30'd0, bus.grant}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
